// File: rtl/set_grid_pkg.sv
// Shared definitions for the grid set-counting block: the mode selector encoding
// and the job sequencing states.
package set_grid_pkg;

  localparam logic [2:0] MODE_A        = 3'd0;
  localparam logic [2:0] MODE_AND_AB   = 3'd1;
  localparam logic [2:0] MODE_XOR_AB   = 3'd2;
  localparam logic [2:0] MODE_TWO_OF_3 = 3'd3;
  localparam logic [2:0] MODE_AND_ABC  = 3'd4;
  localparam logic [2:0] MODE_OR_ABC   = 3'd5;
  localparam logic [2:0] MODE_AB_NOT_C = 3'd6;
  localparam logic [2:0] MODE_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/set_point_eval.sv
// Combinational membership test of one grid point against three circles,
// combined according to the selected set expression.
module set_point_eval
  import set_grid_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [6*COORD_W-1:0] central,
  input  logic [3*COORD_W-1:0] radius,
  input  logic [2:0]           mode,
  output logic                 hit
);

  // Differences are one bit wider than the coordinates so off-grid centres
  // (0 or above GRID) never wrap; the squared sum is kept at full width.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, py, cx, cy, r);
    logic signed [COORD_W:0]     dx, dy;
    logic signed [2*COORD_W+1:0] dxe, dye, sqx, sqy;
    logic        [2*COORD_W+2:0] dist2, re, r2;
    dx    = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy    = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxe   = {{(COORD_W+1){dx[COORD_W]}}, dx};
    dye   = {{(COORD_W+1){dy[COORD_W]}}, dy};
    sqx   = dxe * dxe;
    sqy   = dye * dye;
    dist2 = {1'b0, sqx} + {1'b0, sqy};
    re    = {{(COORD_W+3){1'b0}}, r};
    r2    = re * re;
    return dist2 <= r2;
  endfunction

  logic in_a, in_b, in_c;

  assign in_a = in_circle(x, y, central[6*COORD_W-1 -: COORD_W],
                          central[5*COORD_W-1 -: COORD_W], radius[3*COORD_W-1 -: COORD_W]);
  assign in_b = in_circle(x, y, central[4*COORD_W-1 -: COORD_W],
                          central[3*COORD_W-1 -: COORD_W], radius[2*COORD_W-1 -: COORD_W]);
  assign in_c = in_circle(x, y, central[2*COORD_W-1 -: COORD_W],
                          central[COORD_W-1:0], radius[COORD_W-1:0]);

  always_comb begin
    // NOTE: assign a default first so no path through the case leaves hit unassigned (no latch).
    hit = 1'b0;
    case (mode)
      MODE_A:        hit = in_a;
      MODE_AND_AB:   hit = in_a & in_b;
      MODE_XOR_AB:   hit = in_a ^ in_b;
      MODE_TWO_OF_3: hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
      MODE_AND_ABC:  hit = in_a & in_b & in_c;
      MODE_OR_ABC:   hit = in_a | in_b | in_c;
      MODE_AB_NOT_C: hit = in_a & in_b & ~in_c;
      MODE_RSVD:     hit = 1'b0;
      default:       hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/set_grid_counter.sv
// Counts grid points satisfying a three-circle set expression, scanning LANES
// points per cycle in row-major order and reporting the total with a valid strobe.
module set_grid_counter
  import set_grid_pkg::*;
#(
  parameter  int GRID    = 8,
  parameter  int LANES   = 2,
  localparam int COORD_W = $clog2(GRID) + 1,
  localparam int CNT_W   = $clog2(GRID*GRID + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [6*COORD_W-1:0] central,
  input  logic [3*COORD_W-1:0] radius,
  input  logic [2:0]           mode,
  output logic                 busy,
  output logic                 valid,
  output logic [CNT_W-1:0]     candidate
);

  localparam int LOG_G     = $clog2(GRID);
  localparam int P_W       = 2 * LOG_G;
  localparam int LAST_BASE = GRID*GRID - LANES;

  if (!(GRID == 4 || GRID == 8 || GRID == 16)) begin : g_bad_grid
    $error("set_grid_counter: GRID must be 4, 8 or 16");
  end
  if (!is_pow2(LANES) || LANES > GRID) begin : g_bad_lanes
    $error("set_grid_counter: LANES must be a power of two dividing GRID");
  end

  state_t               state_q, state_d;
  logic [6*COORD_W-1:0] central_q;
  logic [3*COORD_W-1:0] radius_q;
  logic [2:0]           mode_q;
  logic [P_W-1:0]       base_q;
  logic [CNT_W-1:0]     acc_q, acc_next, hit_cnt, cand_q;
  logic [LANES-1:0]     hits;
  logic                 last_batch;

  // base_q is the index of the first point of the batch; lanes take the
  // following consecutive points, so x-1 and y-1 are just its bit fields.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [P_W-1:0]     pt;
    logic [COORD_W-1:0] px, py;
    assign pt = base_q + P_W'(l);
    assign px = {1'b0, pt[LOG_G-1:0]} + COORD_W'(1);
    assign py = {1'b0, pt[P_W-1:LOG_G]} + COORD_W'(1);
    set_point_eval #(.COORD_W(COORD_W)) u_eval (
      .x      (px),
      .y      (py),
      .central(central_q),
      .radius (radius_q),
      .mode   (mode_q),
      .hit    (hits[l])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + CNT_W'(hits[i]);
  end

  assign acc_next   = acc_q + hit_cnt;
  assign last_batch = (base_q == P_W'(LAST_BASE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SCAN;
      SCAN:    if (last_batch) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      cand_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          central_q <= central;
          radius_q  <= radius;
          mode_q    <= mode;
          base_q    <= '0;
          acc_q     <= '0;
        end
        SCAN: begin
          acc_q  <= acc_next;
          base_q <= base_q + P_W'(LANES);
          if (last_batch) cand_q <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign candidate = cand_q;

endmodule

// File: tb/tb_set_grid_counter.sv
// Scoreboard bench for set_grid_counter: jobs push expected counts and due cycles,
// a negedge monitor checks busy, valid timing and candidate every cycle.
module tb_set_grid_counter;

  localparam int G     = 8;
  localparam int L     = 2;
  localparam int W     = 4;
  localparam int CNT_W = 7;
  localparam int S     = G*G/L;

  typedef struct {
    int count;
    int due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [6*W-1:0]   central;
  logic [3*W-1:0]   radius;
  logic [2:0]       mode;
  logic             busy, valid;
  logic [CNT_W-1:0] candidate;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_cand = 0;
  exp_t exp_q[$];
  int   starts[$];

  set_grid_counter #(.GRID(G), .LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .central  (central),
    .radius   (radius),
    .mode     (mode),
    .busy     (busy),
    .valid    (valid),
    .candidate(candidate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, want);
    end
  endtask

  // Reference: enumerate every on-grid point with plain integer geometry.
  function automatic int model_count(input logic [6*W-1:0] c, input logic [3*W-1:0] r,
                                     input int m);
    int xs[3], ys[3], rs[3], total, n;
    bit in[3];
    for (int k = 0; k < 3; k++) begin
      xs[k] = int'((c >> (W*(5-2*k))) & 24'hF);
      ys[k] = int'((c >> (W*(4-2*k))) & 24'hF);
      rs[k] = int'((r >> (W*(2-k))) & 12'hF);
    end
    total = 0;
    for (int y = 1; y <= G; y++) begin
      for (int x = 1; x <= G; x++) begin
        n = 0;
        for (int k = 0; k < 3; k++) begin
          in[k] = ((x-xs[k])*(x-xs[k]) + (y-ys[k])*(y-ys[k])) <= rs[k]*rs[k];
          n += int'(in[k]);
        end
        case (m)
          0: total += int'(in[0]);
          1: total += int'(in[0] && in[1]);
          2: total += int'(in[0] != in[1]);
          3: total += int'(n == 2);
          4: total += int'(n == 3);
          5: total += int'(n >= 1);
          6: total += int'(in[0] && in[1] && !in[2]);
          default: ;
        endcase
      end
    end
    return total;
  endfunction

  function automatic logic [6*W-1:0] pack_c(input int xa, ya, xb, yb, xc, yc);
    return {W'(xa), W'(ya), W'(xb), W'(yb), W'(xc), W'(yc)};
  endfunction

  function automatic logic [3*W-1:0] pack_r(input int ra, rb, rc);
    return {W'(ra), W'(rb), W'(rc)};
  endfunction

  // Monitor: decoupled from the driver, runs every falling edge.
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = 1'b0;
    foreach (starts[i]) if (cyc >= starts[i] && cyc <= starts[i] + S) exp_busy = 1'b1;
    check("busy", int'(busy), int'(exp_busy));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("valid_at_due", int'(valid), 1);
      check("candidate", int'(candidate), exp_q[0].count);
      last_cand = exp_q[0].count;
      void'(exp_q.pop_front());
    end else begin
      check("valid_quiet", int'(valid), 0);
      check("candidate_hold", int'(candidate), last_cand);
    end
  end

  task automatic start_job(input logic [6*W-1:0] c, input logic [3*W-1:0] r,
                           input logic [2:0] m, input int want);
    exp_t e;
    @(negedge clk);
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    e.count = want;
    e.due   = cyc + 1 + S;
    exp_q.push_back(e);
    starts.push_back(cyc + 1);
    @(negedge clk);
    en      = 1'b0;
    central = 24'($urandom);
    radius  = 12'($urandom);
    mode    = 3'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2*S + 8; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic run_job(input logic [6*W-1:0] c, input logic [3*W-1:0] r,
                         input logic [2:0] m, input int want);
    start_job(c, r, m, want);
    wait_idle();
  endtask

  initial begin
    #(400_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6*W-1:0] c;
    logic [3*W-1:0] r;
    logic [2:0]     m;
    exp_t           e;
    int             n0;

    rst = 1'b0; en = 1'b0; central = '0; radius = '0; mode = '0;
    #3;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_candidate", int'(candidate), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Directed cases with hand-derived counts.
    run_job(pack_c(4, 4, 0, 0, 0, 0), pack_r(0, 0, 0), 3'd0, 1);
    run_job(pack_c(4, 4, 0, 0, 0, 0), pack_r(8, 0, 0), 3'd0, 64);
    run_job(pack_c(1, 1, 8, 8, 0, 0), pack_r(1, 1, 0), 3'd1, 0);
    run_job(pack_c(3, 3, 3, 3, 5, 5), pack_r(2, 2, 1), 3'd2, 0);
    run_job(pack_c(2, 2, 7, 7, 2, 7), pack_r(1, 1, 1), 3'd5, 15);
    run_job(pack_c(2, 2, 7, 7, 2, 7), pack_r(1, 1, 1), 3'd7, 0);
    run_job(pack_c(0, 0, 0, 0, 0, 0), pack_r(0, 0, 0), 3'd0, 0);
    run_job(pack_c(9, 4, 0, 0, 0, 0), pack_r(1, 0, 0), 3'd0, 1);
    run_job(pack_c(0, 0, 0, 0, 0, 0), pack_r(2, 0, 0), 3'd0, 1);
    run_job(pack_c(15, 15, 0, 0, 0, 0), pack_r(0, 0, 0), 3'd0, 0);

    // en pulsed mid-scan with different inputs must be ignored.
    start_job(pack_c(2, 2, 7, 7, 2, 7), pack_r(1, 1, 1), 3'd5, 15);
    repeat (4) @(negedge clk);
    en = 1'b1; central = pack_c(4, 4, 4, 4, 4, 4); radius = pack_r(8, 8, 8); mode = 3'd0;
    @(negedge clk);
    en = 1'b0;
    wait_idle();

    // en held high across DONE: second job starts only from IDLE, two edges later.
    @(negedge clk);
    c = pack_c(5, 3, 6, 6, 1, 8); r = pack_r(3, 2, 4); m = 3'd3;
    central = c; radius = r; mode = m; en = 1'b1;
    n0 = cyc;
    e.count = model_count(c, r, 3); e.due = n0 + 1 + S;         exp_q.push_back(e);
    e.due   = n0 + 1 + S + 2 + S;                               exp_q.push_back(e);
    starts.push_back(n0 + 1);
    starts.push_back(n0 + S + 3);
    repeat (2*S + 4) @(negedge clk);
    en = 1'b0;
    wait_idle();

    // Reset in the middle of a scan aborts the job with no valid pulse.
    start_job(pack_c(4, 4, 0, 0, 0, 0), pack_r(8, 0, 0), 3'd0, 64);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    void'(exp_q.pop_back());
    starts.delete();
    last_cand = 0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_candidate", int'(candidate), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    run_job(pack_c(2, 2, 7, 7, 2, 7), pack_r(1, 1, 1), 3'd5, 15);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 24; j++) begin
      c = 24'($urandom);
      r = 12'($urandom);
      m = 3'($urandom_range(0, 7));
      run_job(c, r, m, model_count(c, r, int'(m)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
